// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a valid/ready handshake.
// Two-entry main/skid buffer keeps in_ready off any combinational path from out_ready.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     In,
    input  logic [2:0]      ImmSrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ImmExt,
    output logic            ImmErr
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [31:0]     raw;
    logic            raw_sx;
    logic            new_err;
    logic [XLEN-1:0] new_imm;

    // Opcode bits never carry immediate data.
    logic unused_opcode;
    assign unused_opcode = ^In[6:0];

    always_comb begin
        raw     = 32'b0;
        raw_sx  = 1'b0;
        new_err = 1'b0;
        case (ImmSrc)
            3'b000: begin raw = {{20{In[31]}}, In[31:20]};                              raw_sx = 1'b1; end
            3'b001: begin raw = {{20{In[31]}}, In[31:25], In[11:7]};                    raw_sx = 1'b1; end
            3'b010: begin raw = {{20{In[31]}}, In[7], In[30:25], In[11:8], 1'b0};       raw_sx = 1'b1; end
            3'b011: begin raw = {In[31:12], 12'b0};                                     raw_sx = 1'b1; end
            3'b100: begin raw = {{12{In[31]}}, In[19:12], In[20], In[30:21], 1'b0};     raw_sx = 1'b1; end
            3'b101: raw = {27'b0, In[19:15]};
            3'b110: raw = (XLEN == 64) ? {26'b0, In[25:20]} : {27'b0, In[24:20]};
            default: new_err = 1'b1;
        endcase
        new_imm = raw_sx ? XLEN'($signed(raw)) : XLEN'(raw);
    end

    logic            main_valid, skid_valid, in_ready_q;
    logic [XLEN-1:0] main_imm, skid_imm;
    logic            main_err, skid_err;
    logic            accept, main_free;

    assign accept    = in_valid && in_ready_q;
    assign main_free = !main_valid || out_ready;

    // in_ready_q always mirrors !skid_valid, kept as its own flop so the port is register-driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_err   <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_imm   <= skid_imm;
                main_err   <= skid_err;
                skid_valid <= 1'b0;
                in_ready_q <= 1'b1;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_imm   <= new_imm;
                main_err   <= new_err;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= new_imm;
            skid_err   <= new_err;
            in_ready_q <= 1'b0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign ImmExt    = main_imm;
    assign ImmErr    = main_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 instance under handshake stress,
// XLEN=64 instance for the wide-extension cases.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, ImmErr;
    logic [31:0] ins, ImmExt;
    logic [2:0]  src;

    logic        v64, rdy64, ov64, err64;
    logic [31:0] in64;
    logic [2:0]  src64;
    logic [63:0] imm64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .In(ins), .ImmSrc(src), .out_valid(out_valid), .out_ready(out_ready),
        .ImmExt(ImmExt), .ImmErr(ImmErr)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64),
        .In(in64), .ImmSrc(src64), .out_valid(ov64), .out_ready(1'b1),
        .ImmExt(imm64), .ImmErr(err64)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference extraction, packed as {imm[63:0], err}.
    function automatic logic [64:0] ref_imm(input logic [31:0] i, input logic [2:0] s, input bit x64);
        logic [31:0] r;
        bit          sx;
        logic        e;
        r = 32'b0; sx = 1'b0; e = 1'b0;
        case (s)
            3'd0: begin r = {{20{i[31]}}, i[31:20]}; sx = 1'b1; end
            3'd1: begin r = {{20{i[31]}}, i[31:25], i[11:7]}; sx = 1'b1; end
            3'd2: begin r = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; sx = 1'b1; end
            3'd3: begin r = {i[31:12], 12'b0}; sx = 1'b1; end
            3'd4: begin r = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; sx = 1'b1; end
            3'd5: r = {27'b0, i[19:15]};
            3'd6: r = x64 ? {26'b0, i[25:20]} : {27'b0, i[24:20]};
            default: e = 1'b1;
        endcase
        if (x64 && sx) return {{32{r[31]}}, r, e};
        return {32'b0, r, e};
    endfunction

    logic [64:0] q[$];
    logic [64:0] exp_cur;
    logic [64:0] prev_out;
    bit          hold_prev = 1'b0;
    bit          acc_prev  = 1'b0;
    bit          rand_or   = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (acc_prev) chk("latency", 65'(out_valid), 65'd1);
            if (hold_prev) chk("hold", {32'b0, ImmExt, ImmErr}, prev_out);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("sb_underflow", 65'(q.size()), 65'd1);
                else chk("imm", {32'b0, ImmExt, ImmErr}, q.pop_front());
            end
            acc_prev  = in_valid && in_ready;
            if (acc_prev) q.push_back(exp_cur);
            hold_prev = out_valid && !out_ready;
            prev_out  = {32'b0, ImmExt, ImmErr};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [31:0] i, input logic [2:0] s, input logic [64:0] e);
        int n;
        ins = i; src = s; exp_cur = e; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk("send_timeout", 65'(in_ready), 65'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_m(input logic [31:0] i, input logic [2:0] s);
        send(i, s, ref_imm(i, s, 1'b0));
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 65'(q.size()), 65'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ins = '0; src = '0; exp_cur = '0;
        v64 = 1'b0; in64 = '0; src64 = '0;
        #1;
        chk("rst_in_ready", 65'(in_ready), 65'd1);
        chk("rst_out_valid", 65'(out_valid), 65'd0);
        chk("rst_imm", {32'b0, ImmExt, ImmErr}, 65'd0);
        #11 rst = 1'b0;
        @(posedge clk);
        #1;

        // All five signed formats, back to back.
        send(32'hFFF00093, 3'd0, {32'b0, 32'hFFFFFFFF, 1'b0});
        send(32'hFE512E23, 3'd1, {32'b0, 32'hFFFFFFFC, 1'b0});
        send(32'hFE000CE3, 3'd2, {32'b0, 32'hFFFFFFF8, 1'b0});
        send(32'h123450B7, 3'd3, {32'b0, 32'h12345000, 1'b0});
        send(32'hFFDFF06F, 3'd4, {32'b0, 32'hFFFFFFFC, 1'b0});
        // Z, SH, illegal.
        send(32'h0207D073, 3'd5, {32'b0, 32'h0000000F, 1'b0});
        send(32'h0207D073, 3'd6, {32'b0, 32'h00000000, 1'b0});
        send(32'h0207D073, 3'd7, {32'b0, 32'h00000000, 1'b1});
        drain();

        // Backpressure: out_ready low for cycles 2-4 of a 4-item burst.
        fork
            begin
                for (int k = 1; k <= 4; k++)
                    send({8'h00, 4'(k), 20'h00093}, 3'd0, {32'b0, 32'(k), 1'b0});
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b1;
                @(posedge clk); #1 out_ready = 1'b0;
                @(negedge clk);
                chk("bp_ready_c2", 65'(in_ready), 65'd1);
                @(posedge clk); #1;
                @(negedge clk);
                chk("bp_ready_c3", 65'(in_ready), 65'd0);
                chk("bp_out_c3", {32'b0, ImmExt, out_valid}, {32'b0, 32'd1, 1'b1});
                @(posedge clk); #1;
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Random handshake.
        rand_or = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_m($urandom, 3'($urandom_range(0, 7)));
        end
        in_valid = 1'b0;
        rand_or = 1'b0;
        drain();

        // Reset mid-stall with both entries full.
        out_ready = 1'b0;
        send_m(32'h7FF00093, 3'd0);
        send_m(32'h80000037, 3'd3);
        in_valid = 1'b0;
        @(negedge clk);
        chk("fill_ready", 65'(in_ready), 65'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 65'(out_valid), 65'd0);
        chk("mid_rst_in_ready", 65'(in_ready), 65'd1);
        chk("mid_rst_imm", {32'b0, ImmExt, ImmErr}, 65'd0);
        q.delete();
        hold_prev = 1'b0;
        acc_prev = 1'b0;
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'h00A00093, 3'd0, {32'b0, 32'd10, 1'b0});
        in_valid = 1'b0;
        drain();

        // XLEN=64 instance.
        @(posedge clk); #1;
        v64 = 1'b1; in64 = 32'h800000B7; src64 = 3'd3;
        @(posedge clk); #1;
        in64 = 32'h03F01093; src64 = 3'd6;
        @(negedge clk);
        chk("x64_u_valid", 65'(ov64), 65'd1);
        chk("x64_u", {imm64, err64}, {64'hFFFFFFFF80000000, 1'b0});
        @(posedge clk); #1;
        v64 = 1'b0;
        @(negedge clk);
        chk("x64_sh", {imm64, err64}, {64'h000000000000003F, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RV32I/RV64I decode stage. It extracts and extends the immediate of every base instruction format (I, S, B, U, J), plus the CSR zero-extended immediate and the unsigned shift amount. Results are registered behind a valid/ready handshake with a two-entry skid buffer, so decode can be stalled by execute without a combinational ready path. It replaces the combinational I/S/B-only extender and produces a defined result for every select value, including illegal ones.

## Interface
- `XLEN`, default 32: output width. Legal values are 32 and 64; any other value is an elaboration error.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `in_valid` input, 1: `In`/`ImmSrc` are valid this cycle.
- `in_ready` output, 1: block can accept an input. Driven directly from a register.
- `In` input, 32: raw instruction word.
- `ImmSrc` input, 3: format select (encodings below).
- `out_valid` output, 1: `ImmExt`/`ImmErr` hold a valid result.
- `out_ready` input, 1: downstream accepts the result this cycle.
- `ImmExt` output, XLEN: extended immediate.
- `ImmErr` output, 1: result came from an illegal `ImmSrc`.

## Operation
Sign extension means replicating `In[31]` up to bit XLEN-1.
- **000, I-type**: sext(`In[31:20]`).
- **001, S-type**: sext({`In[31:25]`, `In[11:7]`}).
- **010, B-type**: sext({`In[31]`, `In[7]`, `In[30:25]`, `In[11:8]`, 1'b0}).
- **011, U-type**: sext({`In[31:12]`, 12'b0}). For XLEN=64, bits 63:32 copy `In[31]`.
- **100, J-type**: sext({`In[31]`, `In[19:12]`, `In[20]`, `In[30:21]`, 1'b0}).
- **101, Z (CSR zimm)**: zero-extend `In[19:15]`.
- **110, SH (shamt)**: zero-extend `In[24:20]` when XLEN=32; zero-extend `In[25:20]` when XLEN=64.
- **111, illegal**: `ImmExt` = 0, `ImmErr` = 1.

For every legal `ImmSrc` value, `ImmErr` = 0. No X is ever driven on `ImmExt`.

Datapath:
- Extraction is combinational on the input side.
- Results land in a main output register, `main`, or a skid register, `skid`. Each is a {valid, ImmExt, ImmErr} entry.
- Accept happens when `in_valid && in_ready`.
- `in_ready` = !`skid.valid`.
- Output fire happens when `out_valid && out_ready`.
- `out_valid` = `main.valid`.

Per-cycle update rule, where "main free" means !`main.valid` or output fire:
- **main free, skid valid**: main loads skid, and skid clears. An accept cannot occur in this cycle because `in_ready` = 0.
- **main free, skid empty, accept**: main loads the new result.
- **main free, skid empty, no accept**: `main.valid` clears.
- **main not free, accept**: skid loads the new result.
- **main not free, no accept**: hold.

Ordering is strictly FIFO. Results are never dropped, duplicated or reordered.

Reset:
- Reset can assert at any time, including mid-stall. It immediately clears both valid bits, zeroes `ImmExt` and `ImmErr`, and drives `in_ready` = 1 and `out_valid` = 0.
- In-flight results are discarded.
- After reset deasserts, the first accept is allowed on the next rising edge.

## Timing
- Latency is 1 cycle: an input accepted at edge N is visible with `out_valid` = 1 after edge N.
- Throughput is 1 result per cycle while `out_ready` = 1.
- Stall behaviour:
  - `out_ready` low for one cycle: the in-flight input goes to skid and `in_ready` falls on the next cycle.
  - Capacity is 2 results. `in_ready` is low only when both entries are full.
- Recovery: with both entries full, `out_ready` rising drains main from skid in that cycle. `in_ready` returns to 1 in the following cycle.
- Holding rule: `ImmExt`/`ImmErr` stay stable while `out_valid && !out_ready`.
- `in_valid` may drop without an accept. Nothing is captured in that case.
- Illegal `ImmSrc` values follow the same handshake and latency as legal ones.

## Test plan
- **All five formats, XLEN=32, `out_ready`=1**: back-to-back inputs {`FFF00093`/I, `FE512E23`/S, `FE000CE3`/B, `123450B7`/U, `FFDFF06F`/J}. Outputs must be `FFFFFFFF`, `FFFFFFFC`, `FFFFFFF8`, `12345000`, `FFFFFFFC` on consecutive cycles with `ImmErr`=0.
- **Z, SH and illegal**: `In`=`0207D073`. ImmSrc 101 -> `0000000F`; 110 -> `00000000`; 111 -> `00000000` with `ImmErr`=1.
- **XLEN=64**: `In`=`800000B7`/U -> `FFFFFFFF80000000`. `In`=`03F01093`/SH -> `000000000000003F`.
- **Backpressure**:
  - `in_valid` held high with values 1, 2, 3, 4 as I-type (`In`=`00N00093`); `out_ready` low for cycles 2–4.
  - `in_ready` must go low after two results are buffered.
  - The output must hold 1 until `out_ready` rises, then emit 1, 2, 3, 4 in order with no loss.
- **Random handshake**: 1000 random inputs with random `in_valid`/`out_ready`. The scoreboard must match a reference extraction model exactly and in order.
- **Reset mid-stall**:
  - Fill both entries, then pulse `rst` asynchronously between edges.
  - `out_valid`=0, `in_ready`=1 and `ImmExt`=0 must hold immediately.
  - The next accepted input must appear 1 cycle later with no stale data.
